nash_driver: RTL and testbench

- Time-step sequencer that drives the control/wspike interface of one LIF neuron core and samples its spike and membrane outputs.
- Accepts weighted input-spike events over a valid/ready stream and clears the neuron once per run.
- Issues one integrate command per event with a fresh 8-bit tag, then one leak/fire command per time step.
- Counts output spikes and reports status to the PS-side register block.

---
 rtl/nash_driver.sv | 192 +++++++++++++++++++
 tb/tb_nash_driver.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nash_driver.sv
// nash_driver: time-step sequencer for a single LIF neuron core.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   IDLE    | waiting for start; control word is zero
//   CLEAR   | neuron clear command (control = 0x0001)
//   WAIT_EV | ev_ready high, waiting for the next weighted input event
//   INTEG   | integrate command carrying a fresh tag, wspike = event weight
//   LEAK    | leak/fire command; spike and V are sampled this cycle
//   DONE    | one-cycle done pulse, then back to IDLE
//
// Every output is registered. The output decode runs on the next state, so
// the word a state presents is visible during the cycle the FSM sits in that
// state. The neuron sees the command for the whole of that cycle.
module nash_driver #(
  parameter int W_WIDTH   = 16,
  parameter int VM_WIDTH  = 31,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] num_steps,
  input  logic                 ev_valid,
  output logic                 ev_ready,
  input  logic [W_WIDTH-1:0]   ev_weight,
  input  logic                 ev_last,
  output logic [W_WIDTH-1:0]   wspike,
  output logic [15:0]          control,
  input  logic                 spike,
  input  logic [VM_WIDTH-1:0]  membrane_potential,
  output logic                 busy,
  output logic                 done,
  output logic                 spike_out,
  output logic [CNT_WIDTH-1:0] spike_count,
  output logic [CNT_WIDTH-1:0] step_count,
  output logic [VM_WIDTH-1:0]  last_vm
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_WAIT_EV = 3'd2,
    S_INTEG   = 3'd3,
    S_LEAK    = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_INTEG = 8'h02;
  localparam logic [7:0] CMD_LEAK  = 8'h04;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] num_steps_q, num_steps_d;
  logic [CNT_WIDTH-1:0] spike_count_q, spike_count_d;
  logic [CNT_WIDTH-1:0] step_count_q, step_count_d;
  logic [VM_WIDTH-1:0]  last_vm_q, last_vm_d;
  logic [7:0]           tag_q, tag_d;
  logic                 last_ev_q, last_ev_d;
  logic [W_WIDTH-1:0]   wspike_q, wspike_d;
  logic [15:0]          control_q, control_d;
  logic                 ev_ready_q, ev_ready_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 spike_out_q, spike_out_d;
  logic                 ev_hs;

  // ev_ready_q is only ever high while sitting in WAIT_EV
  assign ev_hs = ev_valid & ev_ready_q;

  // Next-state, counters, tag and event latch
  always_comb begin
    state_d       = state_q;
    num_steps_d   = num_steps_q;
    spike_count_d = spike_count_q;
    step_count_d  = step_count_q;
    last_vm_d     = last_vm_q;
    tag_d         = tag_q;
    last_ev_d     = last_ev_q;
    wspike_d      = wspike_q;
    spike_out_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d       = S_CLEAR;
          num_steps_d   = num_steps;
          spike_count_d = '0;
          step_count_d  = '0;
          tag_d         = '0;
        end
      end
      S_CLEAR: begin
        state_d = (num_steps_q != '0) ? S_WAIT_EV : S_DONE;
      end
      S_WAIT_EV: begin
        if (ev_hs) begin
          // pre-increment: the first integrate after CLEAR carries tag 1,
          // never equal to the neuron's post-clear tag of 0
          tag_d     = tag_q + 8'd1;
          wspike_d  = ev_weight;
          last_ev_d = ev_last;
          state_d   = S_INTEG;
        end
      end
      S_INTEG: begin
        state_d = last_ev_q ? S_LEAK : S_WAIT_EV;
      end
      S_LEAK: begin
        last_vm_d = membrane_potential;
        if (spike) begin
          spike_out_d = 1'b1;
          if (spike_count_q != {CNT_WIDTH{1'b1}}) begin
            spike_count_d = spike_count_q + 1'b1;
          end
        end
        step_count_d = step_count_q + 1'b1;
        state_d      = (step_count_d == num_steps_q) ? S_DONE : S_WAIT_EV;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Registered output decode from the state being entered
  always_comb begin
    control_d  = '0;
    ev_ready_d = 1'b0;
    done_d     = 1'b0;
    busy_d     = (state_d != S_IDLE);

    unique case (state_d)
      S_CLEAR:   control_d  = {8'h00, CMD_CLEAR};
      S_WAIT_EV: begin
        control_d  = {tag_d, 8'h00};
        ev_ready_d = 1'b1;
      end
      S_INTEG:   control_d  = {tag_d, CMD_INTEG};
      S_LEAK:    control_d  = {tag_d, CMD_LEAK};
      S_DONE:    done_d     = 1'b1;
      default:   control_d  = '0;
    endcase
  end

  // State and output registers; resetn abandons any run in progress
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= S_IDLE;
      num_steps_q   <= '0;
      spike_count_q <= '0;
      step_count_q  <= '0;
      last_vm_q     <= '0;
      tag_q         <= '0;
      last_ev_q     <= 1'b0;
      wspike_q      <= '0;
      control_q     <= '0;
      ev_ready_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      spike_out_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      num_steps_q   <= num_steps_d;
      spike_count_q <= spike_count_d;
      step_count_q  <= step_count_d;
      last_vm_q     <= last_vm_d;
      tag_q         <= tag_d;
      last_ev_q     <= last_ev_d;
      wspike_q      <= wspike_d;
      control_q     <= control_d;
      ev_ready_q    <= ev_ready_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      spike_out_q   <= spike_out_d;
    end
  end

  assign ev_ready    = ev_ready_q;
  assign wspike      = wspike_q;
  assign control     = control_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign spike_out   = spike_out_q;
  assign spike_count = spike_count_q;
  assign step_count  = step_count_q;
  assign last_vm     = last_vm_q;

endmodule

// File: tb/tb_nash_driver.sv
// Bench for nash_driver with a small behavioural LIF neuron attached:
// clear zeroes V and tag, integrate adds wspike only on a new tag,
// leak/fire resets V on spike and otherwise subtracts 10 (floor 0).
// Spike is V > 200.
module tb_nash_driver;

  localparam int THRESH = 200;
  localparam int LEAK   = 10;

  logic        clk;
  logic        resetn;
  logic        start;
  logic [15:0] num_steps;
  logic        ev_valid;
  logic        ev_ready;
  logic [15:0] ev_weight;
  logic        ev_last;
  logic [15:0] wspike;
  logic [15:0] control;
  logic        spike;
  logic [30:0] membrane_potential;
  logic        busy;
  logic        done;
  logic        spike_out;
  logic [15:0] spike_count;
  logic [15:0] step_count;
  logic [30:0] last_vm;

  nash_driver dut (
    .clk                (clk),
    .resetn             (resetn),
    .start              (start),
    .num_steps          (num_steps),
    .ev_valid           (ev_valid),
    .ev_ready           (ev_ready),
    .ev_weight          (ev_weight),
    .ev_last            (ev_last),
    .wspike             (wspike),
    .control            (control),
    .spike              (spike),
    .membrane_potential (membrane_potential),
    .busy               (busy),
    .done               (done),
    .spike_out          (spike_out),
    .spike_count        (spike_count),
    .step_count         (step_count),
    .last_vm            (last_vm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // neuron model (not affected by resetn)
  logic [30:0] nv   = '0;
  logic [7:0]  ntag = '0;
  assign spike              = (nv > 31'(THRESH));
  assign membrane_potential = nv;

  always @(posedge clk) begin
    if (control[0]) begin
      nv   <= '0;
      ntag <= '0;
    end else if (control[1] && control[15:8] != ntag) begin
      nv   <= nv + {15'd0, wspike};
      ntag <= control[15:8];
    end else if (control[2]) begin
      if (spike)                nv <= '0;
      else if (nv > 31'(LEAK))  nv <= nv - 31'(LEAK);
      else                      nv <= '0;
    end
  end

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // monitor state
  logic [15:0] ctl_log[$];
  time         hs_t[$];
  logic [7:0]  exp_tag      = '0;
  logic [7:0]  last_int_tag = '0;
  int          int_count    = 0;
  int          rdy_cycles   = 0;
  int          spk_pulses   = 0;

  always @(posedge clk) begin
    if (resetn && ev_valid && ev_ready) hs_t.push_back($time);
  end

  always @(negedge clk) begin
    if (control[2:0] != 3'b000) ctl_log.push_back(control);
    if (control[0]) exp_tag = 8'd0;
    if (control[1]) begin
      exp_tag      = exp_tag + 8'd1;
      int_count    = int_count + 1;
      last_int_tag = control[15:8];
      chk("integ_tag", 64'(control[15:8]), 64'(exp_tag));
      chk("ready_low_in_integ", 64'(ev_ready), 64'd0);
    end
    if (control[2]) chk("leak_tag", 64'(control[15:8]), 64'(exp_tag));
    if (ev_ready)  rdy_cycles = rdy_cycles + 1;
    if (spike_out) spk_pulses = spk_pulses + 1;
  end

  task automatic do_start(input logic [15:0] n);
    @(negedge clk);
    ctl_log.delete();
    hs_t.delete();
    int_count  = 0;
    rdy_cycles = 0;
    spk_pulses = 0;
    start      = 1'b1;
    num_steps  = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Presents an event and returns on the negedge right after its handshake.
  // ev_valid is left high so back-to-back calls model a stalled producer.
  task automatic send_ev(input logic [15:0] w, input logic l);
    int t;
    t         = 0;
    ev_valid  = 1'b1;
    ev_weight = w;
    ev_last   = l;
    while (!ev_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("ev_ready_reached", 64'(ev_ready), 64'd1);
    @(negedge clk);
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (!done && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("done_reached", 64'(done), 64'd1);
  endtask

  typedef struct {
    logic [15:0]       nsteps;
    int                nev;
    logic [3:0][15:0]  w;
    logic [3:0]        l;
    logic [30:0]       exp_vm;
    logic [15:0]       exp_sc;
    logic [15:0]       exp_st;
    logic [30:0]       exp_v;
  } vec_t;

  vec_t vecs[7];

  task automatic set_vec(input int i, input logic [15:0] ns, input int nev,
                         input logic [15:0] w0, input logic [15:0] w1,
                         input logic [15:0] w2, input logic [15:0] w3,
                         input logic [3:0] l, input logic [30:0] vm,
                         input logic [15:0] sc, input logic [15:0] st,
                         input logic [30:0] v);
    vecs[i].nsteps = ns;
    vecs[i].nev    = nev;
    vecs[i].w[0]   = w0;
    vecs[i].w[1]   = w1;
    vecs[i].w[2]   = w2;
    vecs[i].w[3]   = w3;
    vecs[i].l      = l;
    vecs[i].exp_vm = vm;
    vecs[i].exp_sc = sc;
    vecs[i].exp_st = st;
    vecs[i].exp_v  = v;
  endtask

  logic [15:0] fire_seq[7];

  initial begin
    //         i  steps nev  w0   w1   w2  w3  last     vm  sc st  V-after
    set_vec(0, 2,    4,  50,  60, 100, 10, 4'b1100, 10,  1, 2, 0);   // fire
    set_vec(1, 1,    1,  30,   0,   0,  0, 4'b0001, 30,  0, 1, 20);  // leak
    set_vec(2, 2,    2,  40,   5,   0,  0, 4'b0011, 35,  0, 2, 25);
    set_vec(3, 3,    3, 120,   0,   0,  0, 4'b0111, 100, 0, 3, 90);  // pure leak steps
    set_vec(4, 2,    3, 150,  60, 250,  0, 4'b0110, 250, 2, 2, 0);
    set_vec(5, 1,    1, 200,   0,   0,  0, 4'b0001, 200, 0, 1, 190); // at threshold
    set_vec(6, 1,    1, 201,   0,   0,  0, 4'b0001, 201, 1, 1, 0);   // just above
    fire_seq[0] = 16'h0001; fire_seq[1] = 16'h0102; fire_seq[2] = 16'h0202;
    fire_seq[3] = 16'h0302; fire_seq[4] = 16'h0304; fire_seq[5] = 16'h0402;
    fire_seq[6] = 16'h0404;

    resetn    = 1'b0;
    start     = 1'b0;
    num_steps = '0;
    ev_valid  = 1'b0;
    ev_weight = '0;
    ev_last   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_control",  64'(control),     64'd0);
    chk("rst_wspike",   64'(wspike),      64'd0);
    chk("rst_ev_ready", 64'(ev_ready),    64'd0);
    chk("rst_busy",     64'(busy),        64'd0);
    chk("rst_done",     64'(done),        64'd0);
    chk("rst_spk_out",  64'(spike_out),   64'd0);
    chk("rst_spk_cnt",  64'(spike_count), 64'd0);
    chk("rst_step_cnt", 64'(step_count),  64'd0);
    chk("rst_last_vm",  64'(last_vm),     64'd0);
    resetn = 1'b1;

    // table-driven runs
    for (int i = 0; i < 7; i++) begin
      do_start(vecs[i].nsteps);
      chk("busy_after_start", 64'(busy), 64'd1);
      for (int e = 0; e < vecs[i].nev; e++) send_ev(vecs[i].w[e], vecs[i].l[e]);
      ev_valid = 1'b0;
      wait_done();
      chk("last_vm",     64'(last_vm),     64'(vecs[i].exp_vm));
      chk("spike_count", 64'(spike_count), 64'(vecs[i].exp_sc));
      chk("step_count",  64'(step_count),  64'(vecs[i].exp_st));
      chk("neuron_v",    64'(nv),          64'(vecs[i].exp_v));
      @(negedge clk);
      chk("done_pulse_1cyc", 64'(done), 64'd0);
      chk("busy_idle",       64'(busy), 64'd0);
      chk("spike_pulses",    64'(spk_pulses), 64'(vecs[i].exp_sc));
      chk("integ_count",     64'(int_count),  64'(vecs[i].nev));
      if (i == 0) begin
        chk("fire_seq_len", 64'(ctl_log.size()), 64'd7);
        for (int k = 0; k < 7 && k < ctl_log.size(); k++)
          chk("fire_seq", 64'(ctl_log[k]), 64'(fire_seq[k]));
      end
    end

    // tag wrap: 256 integrates in one step, tags 1..255 then 0
    do_start(16'd1);
    for (int e = 0; e < 256; e++) send_ev(16'd1, (e == 255));
    ev_valid = 1'b0;
    wait_done();
    chk("wrap_last_vm",  64'(last_vm),     64'd256);
    chk("wrap_spk_cnt",  64'(spike_count), 64'd1);
    @(negedge clk);
    chk("wrap_int_cnt",  64'(int_count),    64'd256);
    chk("wrap_last_tag", 64'(last_int_tag), 64'd0);
    chk("wrap_spk_puls", 64'(spk_pulses),   64'd1);

    // backpressure: ev_valid held high across 5,6,7
    do_start(16'd1);
    send_ev(16'd5, 1'b0);
    send_ev(16'd6, 1'b0);
    send_ev(16'd7, 1'b1);
    ev_valid = 1'b0;
    wait_done();
    chk("bp_last_vm", 64'(last_vm), 64'd18);
    chk("bp_hs_count", 64'(hs_t.size()), 64'd3);
    if (hs_t.size() == 3) begin
      chk("bp_hs_gap1", 64'(hs_t[1] - hs_t[0]), 64'd20);
      chk("bp_hs_gap2", 64'(hs_t[2] - hs_t[1]), 64'd20);
    end
    @(negedge clk);

    // num_steps = 0: CLEAR then DONE, no event window
    do_start(16'd0);
    wait_done();
    chk("zero_step_cnt", 64'(step_count), 64'd0);
    chk("zero_spk_cnt",  64'(spike_count), 64'd0);
    @(negedge clk);
    chk("zero_ready_cycles", 64'(rdy_cycles), 64'd0);
    chk("zero_log_len", 64'(ctl_log.size()), 64'd1);
    if (ctl_log.size() > 0) chk("zero_log_clear", 64'(ctl_log[0]), 64'h0001);

    // start while busy is ignored
    do_start(16'd1);
    start     = 1'b1;
    num_steps = 16'd3;
    @(negedge clk);
    start = 1'b0;
    send_ev(16'd7, 1'b1);
    ev_valid = 1'b0;
    wait_done();
    chk("busy_start_steps", 64'(step_count), 64'd1);
    chk("busy_start_vm",    64'(last_vm),    64'd7);
    @(negedge clk);

    // reset during INTEG of step 3
    do_start(16'd5);
    send_ev(16'd20, 1'b1);
    send_ev(16'd20, 1'b1);
    send_ev(16'd20, 1'b1);
    chk("mid_in_integ", 64'(control[1]), 64'd1);
    resetn   = 1'b0;
    ev_valid = 1'b0;
    @(negedge clk);
    chk("mid_rst_control",  64'(control),     64'd0);
    chk("mid_rst_wspike",   64'(wspike),      64'd0);
    chk("mid_rst_ev_ready", 64'(ev_ready),    64'd0);
    chk("mid_rst_busy",     64'(busy),        64'd0);
    chk("mid_rst_done",     64'(done),        64'd0);
    chk("mid_rst_spk_cnt",  64'(spike_count), 64'd0);
    chk("mid_rst_step_cnt", 64'(step_count),  64'd0);
    chk("mid_rst_last_vm",  64'(last_vm),     64'd0);
    resetn = 1'b1;
    do_start(16'd1);
    send_ev(16'd5, 1'b1);
    ev_valid = 1'b0;
    wait_done();
    chk("post_rst_first_cmd", 64'(ctl_log.size() > 0 ? ctl_log[0] : 16'h0), 64'h0001);
    chk("post_rst_steps",     64'(step_count),  64'd1);
    chk("post_rst_last_vm",   64'(last_vm),     64'd5);
    chk("post_rst_spk_cnt",   64'(spike_count), 64'd0);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
